// File: rtl/trace_replay_driver_pkg.sv
// Shared types for the trace replay driver: trace entry layout and replay state encoding.
package trace_replay_driver_pkg;

  localparam int OP_W   = 2;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
  } trace_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PAUSE,
    S_DONE,
    S_ERR
  } replay_state_t;

endpackage

// File: rtl/trace_replay_driver_trace_mem.sv
// Trace storage: one synchronous write port, combinational read port, no reset on contents.
module trace_mem
  import trace_replay_driver_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  trace_entry_t  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output trace_entry_t  rdata_o
);

  trace_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/trace_replay_driver.sv
// Replays a stored operation trace over a valid/opr_finished handshake.
// States: IDLE load/arm | ISSUE one-cycle valid | WAIT completion | PAUSE await step | DONE pulse | ERR timeout.
module trace_replay_driver
  import trace_replay_driver_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int OP_W    = trace_replay_driver_pkg::OP_W,
  parameter int ADDR_W  = trace_replay_driver_pkg::ADDR_W,
  parameter int TIMEOUT = 64,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [OP_W-1:0]   ld_op,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_clr,
  output logic              ld_full,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  output logic              valid,
  output logic [OP_W-1:0]   op,
  output logic [ADDR_W-1:0] addr,
  input  logic              opr_finished,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  issued_cnt
);

  localparam int AW     = $clog2(DEPTH);
  localparam int WAIT_W = $clog2(TIMEOUT);

  replay_state_t     state_q, state_d;
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              step_mode_q, step_mode_d;
  logic              step_q, step_d;
  logic              terr_q, terr_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic         mem_we;
  logic         full;
  logic         last;
  trace_entry_t wr_entry;
  trace_entry_t rd_entry;

  assign full     = (wr_ptr_q == CNT_W'(DEPTH));
  assign last     = (rd_ptr_q == wr_ptr_q - CNT_W'(1));
  assign wr_entry = '{op: ld_op, addr: ld_addr};

  // Read at the next pointer so op/addr can be registered on entry to ISSUE.
  trace_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_d[AW-1:0]),
    .rdata_o (rd_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (wr_ptr_q == '0)  state_d = S_DONE;
        else if (step_mode)  state_d = S_PAUSE;
        else                 state_d = S_ISSUE;
      end
      S_PAUSE: if (step_q) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (opr_finished) begin
          if (last)             state_d = S_DONE;
          else if (step_mode_q) state_d = S_PAUSE;
          else                  state_d = S_ISSUE;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid = (state_q == S_ISSUE);
    done  = (state_q == S_DONE);
    busy  = (state_q != S_IDLE);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    issued_d    = issued_q;
    wait_d      = wait_q;
    step_mode_d = step_mode_q;
    terr_d      = terr_q;
    mem_we      = 1'b0;
    step_d      = (state_q == S_PAUSE) && step;
    case (state_q)
      S_IDLE: begin
        if (ld_clr) begin
          wr_ptr_d = '0;
        end else if (ld_en && !full) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + CNT_W'(1);
        end
        if (start) begin
          rd_ptr_d    = '0;
          issued_d    = '0;
          terr_d      = 1'b0;
          step_mode_d = step_mode;
        end
      end
      S_ISSUE: wait_d = '0;
      S_WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        if (opr_finished) begin
          issued_d = issued_q + CNT_W'(1);
          if (!last) rd_ptr_d = rd_ptr_q + CNT_W'(1);
        end
      end
      S_ERR:   terr_d = 1'b1;
      default: ;
    endcase
    op_d   = (state_d == S_ISSUE) ? rd_entry.op   : op_q;
    addr_d = (state_d == S_ISSUE) ? rd_entry.addr : addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      issued_q    <= '0;
      wait_q      <= '0;
      step_mode_q <= 1'b0;
      step_q      <= 1'b0;
      terr_q      <= 1'b0;
      op_q        <= '0;
      addr_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      issued_q    <= issued_d;
      wait_q      <= wait_d;
      step_mode_q <= step_mode_d;
      step_q      <= step_d;
      terr_q      <= terr_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
    end
  end

  assign ld_full     = full;
  assign op          = op_q;
  assign addr        = addr_q;
  assign timeout_err = terr_q;
  assign issued_cnt  = issued_q;

endmodule

// File: tb/tb_trace_replay_driver.sv
// Directed bench for trace_replay_driver with a queue-based model of the loaded trace and expected issues.
module tb_trace_replay_driver;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, ld_en, ld_clr, start, step_mode, step, opr_finished;
  logic [1:0]  ld_op, op;
  logic [31:0] ld_addr, addr;
  logic        ld_full, valid, busy, done, timeout_err;
  logic [4:0]  issued_cnt;

  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_done = 0;
  int   run_len = 0;
  bit   resp_en = 1'b1;
  int   resp_dly = 3;
  ent_t trace_q[$];
  ent_t exp_q[$];
  ent_t last_e = '0;
  int   nv0, nd0;

  always #5 clk = ~clk;

  trace_replay_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_op(ld_op), .ld_addr(ld_addr),
    .ld_clr(ld_clr), .ld_full(ld_full), .start(start), .step_mode(step_mode),
    .step(step), .valid(valid), .op(op), .addr(addr), .opr_finished(opr_finished),
    .busy(busy), .done(done), .timeout_err(timeout_err), .issued_cnt(issued_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [1:0] o, input logic [31:0] a);
    ld_en = 1'b1; ld_op = o; ld_addr = a;
    @(posedge clk);
    if (trace_q.size() < DEPTH) trace_q.push_back('{op: o, addr: a});
    #1 ld_en = 1'b0;
  endtask

  task automatic clear();
    ld_clr = 1'b1;
    @(posedge clk);
    trace_q.delete();
    #1 ld_clr = 1'b0;
  endtask

  task automatic start_run(input bit sm);
    exp_q   = trace_q;
    run_len = trace_q.size();
    start = 1'b1; step_mode = sm;
    @(posedge clk); #1;
    start = 1'b0; step_mode = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = n_done;
    int i = 0;
    while (n_done == d0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk("done_seen", 64'(n_done - d0), 1);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  // Completion responder: answers each valid resp_dly cycles later with a one-cycle pulse.
  always begin
    @(negedge clk);
    if (valid && resp_en) begin
      repeat (resp_dly) @(posedge clk);
      #1 opr_finished = 1'b1;
      @(posedge clk);
      #1 opr_finished = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("ld_full", ld_full, trace_q.size() == DEPTH);
      if (valid) begin
        chk("valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) last_e = exp_q.pop_front();
        n_valid++;
      end
      chk("op", op, last_e.op);
      chk("addr", addr, last_e.addr);
      if (valid || done) chk("busy_active", busy, 1);
      if (done) begin
        n_done++;
        chk("issued_at_done", issued_cnt, run_len);
        chk("terr_at_done", timeout_err, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b1; ld_en = 0; ld_clr = 0; start = 0; step_mode = 0; step = 0;
    opr_finished = 0; ld_op = '0; ld_addr = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_op", op, 0);
    chk("rst_addr", addr, 0);
    chk("rst_full", ld_full, 0);
    reset = 1'b0;
    cyc();

    // Basic three-entry replay
    load(2'd1, 32'h10); load(2'd2, 32'h20); load(2'd3, 32'h30);
    nv0 = n_valid;
    start_run(0);
    chk("t1_first_valid", valid, 1);
    chk("t1_first_op", op, 1);
    chk("t1_first_addr", addr, 32'h10);
    wait_done(200);
    chk("t1_valids", 64'(n_valid - nv0), 3);
    chk("t1_issued", issued_cnt, 3);

    // Fill to DEPTH, overflow write dropped
    clear();
    for (int i = 0; i < DEPTH; i++) load(2'(i % 4), 32'h100 + 32'(i * 4));
    chk("t2_full", ld_full, 1);
    load(2'd3, 32'hDEAD);
    chk("t2_still_full", ld_full, 1);
    nv0 = n_valid;
    start_run(0);
    wait_done(400);
    chk("t2_valids", 64'(n_valid - nv0), 16);
    chk("t2_issued", issued_cnt, 16);

    // Timeout: exactly TIMEOUT wait cycles tolerated
    clear();
    load(2'd0, 32'h40);
    resp_en = 1'b0;
    nd0 = n_done;
    start_run(0);
    cyc();
    repeat (TIMEOUT - 1) cyc();
    chk("t3_last_wait_busy", busy, 1);
    chk("t3_last_wait_terr", timeout_err, 0);
    cyc();
    chk("t3_err_busy", busy, 1);
    chk("t3_err_terr", timeout_err, 0);
    cyc();
    chk("t3_idle_busy", busy, 0);
    chk("t3_terr", timeout_err, 1);
    chk("t3_issued", issued_cnt, 0);
    chk("t3_no_done", 64'(n_done - nd0), 0);
    resp_en = 1'b1;
    start_run(0);
    chk("t3_terr_cleared", timeout_err, 0);
    wait_done(50);

    // Single-step mode
    clear();
    load(2'd1, 32'h50); load(2'd2, 32'h60);
    nv0 = n_valid;
    start_run(1);
    repeat (20) cyc();
    chk("t4_no_valid", 64'(n_valid - nv0), 0);
    chk("t4_paused_busy", busy, 1);
    pulse_step();
    chk("t4_step_plus1", valid, 0);
    cyc();
    chk("t4_step_plus2", valid, 1);
    chk("t4_step_op", op, 1);
    repeat (10) cyc();
    chk("t4_paused_again", 64'(n_valid - nv0), 1);
    pulse_step();
    wait_done(50);
    chk("t4_valids", 64'(n_valid - nv0), 2);
    chk("t4_issued", issued_cnt, 2);

    // Reset during WAIT of entry 2
    clear();
    load(2'd1, 32'h70); load(2'd2, 32'h80); load(2'd3, 32'h90);
    nv0 = n_valid;
    nd0 = n_done;
    start_run(0);
    for (int i = 0; i < 50 && (n_valid - nv0) < 2; i++) @(posedge clk);
    chk("t5_reached_entry2", 64'(n_valid - nv0), 2);
    #1 reset = 1'b1;
    trace_q.delete(); exp_q.delete(); last_e = '0;
    #1;
    chk("t5_valid", valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_issued", issued_cnt, 0);
    chk("t5_op", op, 0);
    chk("t5_addr", addr, 0);
    chk("t5_full", ld_full, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) cyc();
    chk("t5_no_done", 64'(n_done - nd0), 0);
    load(2'd3, 32'hA0); load(2'd2, 32'hB0); load(2'd1, 32'hC0);
    start_run(0);
    chk("t5_restart_op", op, 3);
    chk("t5_restart_addr", addr, 32'hA0);
    wait_done(200);

    // Empty trace, and start while busy
    clear();
    nv0 = n_valid;
    start_run(0);
    chk("t6_empty_done", done, 1);
    chk("t6_empty_valid", valid, 0);
    wait_done(10);
    chk("t6_empty_issued", issued_cnt, 0);
    load(2'd2, 32'hD0); load(2'd1, 32'hE0);
    nv0 = n_valid;
    start_run(0);
    cyc(); cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(100);
    chk("t6_busy_start_valids", 64'(n_valid - nv0), 2);
    chk("t6_busy_start_issued", issued_cnt, 2);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
